shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Ports SHALL be, one per line (name  direction  width  meaning), with clock and reset first:
  clk  input  1  single system clock; all state changes on the rising edge
  clear_n  input  1  asynchronous, active-low reset
  start  input  1  request a shift operation
  data_in  input  4  operand to load
  dir  input  1  0 = left (toward q[3]), 1 = right (toward q[0])
  amount  input  3  shift count, 0..7
  mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 treated as logical
  q  input  4  parallel output of the downstream ls74194 (q[3] = MSB)
  s  output  2  ls74194 mode select: 00 hold, 01 right, 10 left, 11 load
  p  output  4  ls74194 parallel load data
  sil  output  1  ls74194 serial-in for a left shift (enters q[0])
  sir  output  1  ls74194 serial-in for a right shift (enters q[3])
  busy  output  1  operation in progress
  done  output  1  one-cycle completion strobe
  result  output  4  final register value, valid while done = 1
  carry  output  1  last bit shifted out
REQ-002 The block SHALL have one clock, clk; reset SHALL be clear_n, asynchronous and active-low.
REQ-003 The block SHALL drive a single ls74194 over its s/p/sil/sir ports and observe that device's q; the ls74194 SHALL share clk and clear_n.

Function
REQ-004 FSM states SHALL be IDLE, LOAD, SHIFT and DONE; outputs s and p SHALL be Moore outputs decoded from the state.
REQ-005 In IDLE, s = 00, busy = 0 and done = 0; start = 1 sampled on a clk edge SHALL register data_in, dir, amount and mode, and go to LOAD.
REQ-006 start SHALL be ignored whenever busy = 1; the registered operands SHALL NOT change until the next IDLE.
REQ-007 In LOAD, s = 11 and p = registered data; the next edge SHALL go to SHIFT if amount != 0, otherwise to DONE.
REQ-008 carry SHALL clear to 0 on the LOAD edge.
REQ-009 In SHIFT, s SHALL be 01 for dir = 1 and 10 for dir = 0.
REQ-010 A 3-bit down-counter SHALL be loaded with amount on the LOAD edge and decrement once per SHIFT cycle; the SHIFT state SHALL last exactly amount cycles, then go to DONE.
REQ-011 sir SHALL be combinational from mode and q: logical = 0, arithmetic = q[3], rotate = q[0].
REQ-012 sil SHALL be combinational from mode and q: logical = 0, arithmetic = 0, rotate = q[3].
REQ-013 sil and sir SHALL be 0 outside SHIFT.
REQ-014 On each SHIFT edge, carry SHALL capture the bit leaving the register: q[0] when dir = 1, q[3] when dir = 0.
REQ-015 In DONE, s = 00, done = 1 and result = q; the next edge SHALL return to IDLE.
REQ-016 busy SHALL be 1 in LOAD, SHIFT and DONE.
REQ-017 Latency SHALL be fixed: done is high in the cycle following edge (start edge + 1 + amount).
REQ-018 amount 4..7 in logical mode SHALL produce result 0000; in rotate mode it SHALL wrap (rotate by amount mod 4 bit positions).
REQ-019 p SHALL equal the registered data in LOAD and 0000 in every other state.

Reset
REQ-020 clear_n = 0 SHALL immediately force, independent of clk, state = IDLE, counter = 0, registered operands = 0, s = 00, p = 0000, sil = 0, sir = 0, busy = 0, done = 0, carry = 0 and result = 0000.
REQ-021 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-022 After clear_n deasserts, the first start SHALL be accepted on the next clk edge.

Verification
REQ-023 Reset: clear_n = 0 with arbitrary inputs -> s = 00, busy = 0, done = 0, carry = 0, result = 0000, q = 0000.
REQ-024 Logical right: data_in = 1010, dir = 1, amount = 1, mode = 00 -> done in cycle 3 with result = 0101 and carry = 0.
REQ-025 Arithmetic right: data_in = 1011, dir = 1, amount = 2, mode = 01 -> intermediate 1101, then result = 1110 and carry = 1.
REQ-026 Rotate left: data_in = 1001, dir = 0, amount = 3, mode = 10 -> sequence 0011, 0110, 1100; result = 1100, carry = 0. A start pulse during busy -> ignored.
REQ-027 Zero count: data_in = 0110, amount = 0 -> LOAD then DONE, done in cycle 2 with result = 0110 and carry = 0. Logical left, data_in = 1111, amount = 5 -> result = 0000, carry = 0.
REQ-028 Mid-operation reset: clear_n pulsed low during SHIFT of an amount = 7 operation -> immediate IDLE with all outputs 0, no done pulse; a new start is accepted afterwards.

Source files
------------

// File: rtl/shift_sequencer.sv
// Sequencer that drives a single ls74194 universal shift register through
// load / shift / done phases to perform logical, arithmetic or rotate shifts.
module shift_sequencer (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       start,
    input  logic [3:0] data_in,
    input  logic       dir,
    input  logic [2:0] amount,
    input  logic [1:0] mode,
    input  logic [3:0] q,
    output logic [1:0] s,
    output logic [3:0] p,
    output logic       sil,
    output logic       sir,
    output logic       busy,
    output logic       done,
    output logic [3:0] result,
    output logic       carry
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_ARITH  = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;

    state_t     state_q, state_d;
    logic [3:0] data_q, data_d;
    logic       dir_q, dir_d;
    logic [2:0] amount_q, amount_d;
    logic [1:0] mode_q, mode_d;
    logic [2:0] cnt_q, cnt_d;
    logic       carry_q, carry_d;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= IDLE;
            data_q   <= 4'b0000;
            dir_q    <= 1'b0;
            amount_q <= 3'd0;
            mode_q   <= 2'b00;
            cnt_q    <= 3'd0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            dir_q    <= dir_d;
            amount_q <= amount_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
        end
    end

    // Operands are only captured in IDLE, so start is ignored while busy.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        dir_d    = dir_q;
        amount_d = amount_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d   = data_in;
                    dir_d    = dir;
                    amount_d = amount;
                    mode_d   = mode;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = amount_q;
                carry_d = 1'b0;
                state_d = (amount_q != 3'd0) ? SHIFT : DONE;
            end
            SHIFT: begin
                cnt_d   = cnt_q - 3'd1;
                carry_d = dir_q ? q[0] : q[3];
                if (cnt_q <= 3'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Serial fill bits depend on the live register contents, not a snapshot.
    always_comb begin
        s      = 2'b00;
        p      = 4'b0000;
        sil    = 1'b0;
        sir    = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        result = 4'b0000;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
            end
            LOAD: begin
                s = 2'b11;
                p = data_q;
            end
            SHIFT: begin
                s = dir_q ? 2'b01 : 2'b10;
                if (mode_q == MODE_ARITH) begin
                    sir = q[3];
                end else if (mode_q == MODE_ROTATE) begin
                    sir = q[0];
                    sil = q[3];
                end
            end
            DONE: begin
                done   = 1'b1;
                result = q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign carry = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioral ls74194 closing the loop
// on q; expected results and carries are hand-computed per vector.
module tb_shift_sequencer;

    logic       clk;
    logic       clear_n;
    logic       start;
    logic [3:0] data_in;
    logic       dir;
    logic [2:0] amount;
    logic [1:0] mode;
    logic [3:0] q;
    logic [1:0] s;
    logic [3:0] p;
    logic       sil;
    logic       sir;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       carry;

    int total = 0;
    int bad   = 0;

    shift_sequencer dut (
        .clk     (clk),
        .clear_n (clear_n),
        .start   (start),
        .data_in (data_in),
        .dir     (dir),
        .amount  (amount),
        .mode    (mode),
        .q       (q),
        .s       (s),
        .p       (p),
        .sil     (sil),
        .sir     (sir),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .carry   (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioral ls74194 sharing clk and clear_n with the sequencer.
    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            q <= 4'b0000;
        end else begin
            case (s)
                2'b01:   q <= {sir, q[3:1]};
                2'b10:   q <= {q[2:0], sil};
                2'b11:   q <= p;
                default: q <= q;
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%b want=%b at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns {bit shifted out, next register value} for one shift step.
    function automatic logic [4:0] shiftModel(input logic [3:0] v, input logic dr, input logic [1:0] md);
        logic fill;
        if (dr) begin
            fill = (md == 2'b01) ? v[3] : (md == 2'b10) ? v[0] : 1'b0;
            return {v[0], fill, v[3:1]};
        end else begin
            fill = (md == 2'b10) ? v[3] : 1'b0;
            return {v[3], v[2:0], fill};
        end
    endfunction

    // Called at a negedge with the sequencer idle; returns at a negedge, idle again.
    task automatic applyStimulus(input logic [3:0] d, input logic dr, input logic [2:0] amt,
                                 input logic [1:0] md, input logic [3:0] expRes,
                                 input logic expCarry, input bit pulseBusy);
        logic [3:0] model;
        logic [4:0] step;
        logic       expSir;
        logic       expSil;
        start   = 1'b1;
        data_in = d;
        dir     = dr;
        amount  = amt;
        mode    = md;
        @(negedge clk);
        start   = 1'b0;
        data_in = ~d;
        dir     = ~dr;
        amount  = ~amt;
        mode    = ~md;
        checkOutput("load_s", {2'b00, s}, 4'b0011);
        checkOutput("load_p", p, d);
        checkOutput("load_busy", {3'b000, busy}, 4'b0001);
        checkOutput("load_done", {3'b000, done}, 4'b0000);
        model = d;
        for (int k = 0; k < int'(amt); k++) begin
            @(negedge clk);
            start = 1'b0;
            checkOutput("shift_s", {2'b00, s}, dr ? 4'b0001 : 4'b0010);
            checkOutput("shift_q", q, model);
            checkOutput("shift_p", p, 4'b0000);
            checkOutput("shift_done", {3'b000, done}, 4'b0000);
            checkOutput("shift_busy", {3'b000, busy}, 4'b0001);
            expSir = (md == 2'b01) ? model[3] : (md == 2'b10) ? model[0] : 1'b0;
            expSil = (md == 2'b10) ? model[3] : 1'b0;
            checkOutput("shift_sir", {3'b000, sir}, {3'b000, expSir});
            checkOutput("shift_sil", {3'b000, sil}, {3'b000, expSil});
            if (k == 0) begin
                checkOutput("carry_clr", {3'b000, carry}, 4'b0000);
                if (pulseBusy) begin
                    start   = 1'b1;
                    data_in = 4'b0000;
                    amount  = 3'd0;
                end
            end
            step  = shiftModel(model, dr, md);
            model = step[3:0];
        end
        @(negedge clk);
        start = 1'b0;
        checkOutput("done_strobe", {3'b000, done}, 4'b0001);
        checkOutput("done_result", result, expRes);
        checkOutput("done_model", result, model);
        checkOutput("done_carry", {3'b000, carry}, {3'b000, expCarry});
        checkOutput("done_s", {2'b00, s}, 4'b0000);
        checkOutput("done_busy", {3'b000, busy}, 4'b0001);
        @(negedge clk);
        checkOutput("idle_done", {3'b000, done}, 4'b0000);
        checkOutput("idle_busy", {3'b000, busy}, 4'b0000);
        checkOutput("idle_result", result, 4'b0000);
        checkOutput("idle_q_hold", q, expRes);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        clear_n = 1'b0;
        start   = 1'b1;
        data_in = 4'b1101;
        dir     = 1'b1;
        amount  = 3'd5;
        mode    = 2'b10;
        #2;
        checkOutput("rst_s", {2'b00, s}, 4'b0000);
        checkOutput("rst_busy", {3'b000, busy}, 4'b0000);
        checkOutput("rst_done", {3'b000, done}, 4'b0000);
        checkOutput("rst_carry", {3'b000, carry}, 4'b0000);
        checkOutput("rst_result", result, 4'b0000);
        checkOutput("rst_q", q, 4'b0000);
        repeat (2) @(negedge clk);
        checkOutput("rst_hold_busy", {3'b000, busy}, 4'b0000);
        checkOutput("rst_hold_p", p, 4'b0000);
        start   = 1'b0;
        clear_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed shift vectors");
        applyStimulus(4'b1010, 1'b1, 3'd1, 2'b00, 4'b0101, 1'b0, 1'b0);
        applyStimulus(4'b1011, 1'b1, 3'd2, 2'b01, 4'b1110, 1'b1, 1'b0);
        applyStimulus(4'b1001, 1'b0, 3'd3, 2'b10, 4'b1100, 1'b0, 1'b1);
        applyStimulus(4'b0110, 1'b0, 3'd0, 2'b00, 4'b0110, 1'b0, 1'b0);
        applyStimulus(4'b1111, 1'b0, 3'd5, 2'b00, 4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b1, 3'd6, 2'b10, 4'b0100, 1'b0, 1'b0);
        applyStimulus(4'b1100, 1'b1, 3'd2, 2'b11, 4'b0011, 1'b0, 1'b0);
        applyStimulus(4'b1000, 1'b1, 3'd7, 2'b01, 4'b1111, 1'b1, 1'b0);

        $display("[TB] mid-operation reset");
        start   = 1'b1;
        data_in = 4'b0101;
        dir     = 1'b1;
        amount  = 3'd7;
        mode    = 2'b00;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("mid_q", q, 4'b0010);
        checkOutput("mid_carry", {3'b000, carry}, 4'b0001);
        #2;
        clear_n = 1'b0;
        #1;
        checkOutput("abort_busy", {3'b000, busy}, 4'b0000);
        checkOutput("abort_s", {2'b00, s}, 4'b0000);
        checkOutput("abort_done", {3'b000, done}, 4'b0000);
        checkOutput("abort_carry", {3'b000, carry}, 4'b0000);
        checkOutput("abort_q", q, 4'b0000);
        checkOutput("abort_sil_sir", {2'b00, sil, sir}, 4'b0000);
        @(negedge clk);
        clear_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("abort_no_done", {3'b000, done}, 4'b0000);
            checkOutput("abort_idle", {3'b000, busy}, 4'b0000);
        end
        clear_n = 1'b0;
        @(negedge clk);
        clear_n = 1'b1;
        applyStimulus(4'b0110, 1'b0, 3'd1, 2'b00, 4'b1100, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
